uart_apb_arbiter: RTL and testbench
===================================

UART_APB_ARBITER -- requirements
Module: uart_apb_arbiter

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
  APB_ADDR_WIDTH, 8, APB address width.
  APB_DATA_WIDTH, 32, APB data width.
  TIMEOUT_CYCLES, 16, maximum wait-state cycles allowed in ACCESS (range 1..255).
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
  i_apb_pclk  in  1  single clock.
  i_apb_presetn  in  1  asynchronous active-low reset.
  i_req  in  2  per-requester request; held high until matching o_done.
  i_addr  in  2*AW  per-requester address; requester r at [r*AW +: AW].
  i_wdata  in  2*DW  per-requester write data.
  i_write  in  2  per-requester direction, 1 = write.
  o_done  out  2  one-cycle completion pulse per requester.
  o_rdata  out  DW  read data, valid with o_done.
  o_err  out  1  error flag, valid with o_done (PSLVERR or timeout).
  o_timeout  out  1  sticky timeout flag, cleared only by reset.
  o_paddr, o_pwdata, o_pwrite, o_psel, o_penable  out  AW/DW/1/1/1  APB3 master request signals.
  i_prdata, i_pready, i_pslverr  in  DW/1/1  APB3 completer response.

Function
REQ-003 The FSM SHALL have four states: IDLE, SETUP, ACCESS, RESP.
REQ-004 In IDLE with any i_req high, the arbiter SHALL latch the winner index, its address, wdata and direction, then move to SETUP.
REQ-005 Arbitration SHALL be round-robin: priority goes to the requester not granted last; after reset, requester 0 has priority.
REQ-006 SETUP SHALL last exactly one cycle: PSEL=1, PENABLE=0, latched PADDR/PWDATA/PWRITE driven. Next state is ACCESS.
REQ-007 ACCESS: PSEL=1, PENABLE=1. When i_pready=1, the arbiter SHALL capture i_prdata (reads only; writes capture 0) and i_pslverr, then move to RESP.
REQ-008 Wait-state counter: cleared on entering ACCESS, incremented each ACCESS cycle with i_pready=0.
REQ-009 When the counter reaches TIMEOUT_CYCLES with i_pready still 0, the arbiter SHALL:
  - leave ACCESS for RESP;
  - set the error to 1 and rdata to 0;
  - set o_timeout.
REQ-010 RESP SHALL last one cycle: o_done[winner]=1, o_rdata/o_err valid. Next state is IDLE unconditionally.
REQ-011 Zero-wait latency: request sampled in IDLE at cycle N gives SETUP at N+1, ACCESS at N+2, o_done at N+3. Each wait state adds one cycle.
REQ-012 No arbitration occurs outside IDLE. Requests arriving mid-transaction SHALL wait. Latched fields SHALL NOT change during a transaction.
REQ-013 Outside RESP: o_done=0, o_rdata=0, o_err=0.
REQ-014 Outside SETUP/ACCESS: o_psel=0, o_penable=0. APB address, data and write signals hold their last value.
REQ-015 Simultaneous i_req=2'b11 on consecutive transactions SHALL alternate grants 0,1,0,1.

Reset
REQ-016 Asynchronous assertion of i_apb_presetn=0 SHALL immediately force:
  - state IDLE, with PSEL/PENABLE/o_done/o_err/o_timeout = 0;
  - o_paddr/o_pwdata/o_rdata = 0, o_pwrite = 0;
  - round-robin pointer so that requester 0 has priority;
  - wait counter = 0.
REQ-017 Reset during SETUP or ACCESS SHALL abort the transfer without any o_done pulse. Deassertion is synchronous to i_apb_pclk at the integrating level.

Structure
REQ-018 The state enum typedef (uart_arb_state_t) and the constant UART_ARB_TIMEOUT_DFLT SHALL live in uart_pkg.
REQ-019 Round-robin grant logic SHALL be one sub-module, uart_rr_arbiter: inputs req[1:0], last-grant, update strobe; output one-hot grant.
REQ-020 The APB master port SHALL connect directly to uart_top's APB3 slave pins.

Verification
REQ-021 Write, zero-wait: req0 writes 0xA5 to 0x04 with PREADY tied high -> PSEL at N+1, PENABLE at N+2, o_done[0] at N+3, o_err=0.
REQ-022 Read, 3 wait states: req1 reads with PRDATA=0x1234 -> PENABLE high 4 cycles, o_done[1] with o_rdata=0x1234.
REQ-023 Contention: both requests held for 4 transactions -> grant order 0,1,0,1; never two o_done bits high in the same cycle.
REQ-024 Timeout: PREADY stuck at 0, TIMEOUT_CYCLES=16 -> after 16 ACCESS cycles PSEL drops, o_done with o_err=1, o_rdata=0, and o_timeout=1 stays set.
REQ-025 PSLVERR: completer returns PREADY=1, PSLVERR=1 -> o_err=1 with o_done, o_timeout stays 0.
REQ-026 Reset in ACCESS: assert reset for 2 cycles -> PSEL/PENABLE fall at once, no o_done; afterwards the next request is served normally with requester 0 priority.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART APB request arbiter.
package uart_pkg;

    // Arbiter transaction phases; SETUP/ACCESS mirror the APB3 phases.
    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StSetup  = 2'd1,
        StAccess = 2'd2,
        StResp   = 2'd3
    } uart_arb_state_t;

    // Default ACCESS wait-state budget before a transfer is abandoned.
    localparam int unsigned UART_ARB_TIMEOUT_DFLT = 16;

endpackage

// File: rtl/uart_rr_arbiter.sv
// Two-way round-robin grant: on contention the requester not granted last wins.
module uart_rr_arbiter (
    input  logic [1:0] req,
    input  logic       last_grant,  // index of the requester granted most recently
    input  logic       update,      // grant is only issued while arbitration is open
    output logic [1:0] grant
);

    // One-hot grant, zero when arbitration is closed or nobody asks.
    always_comb begin
        grant = 2'b00;
        if (update) begin
            if (req == 2'b11) begin
                grant = last_grant ? 2'b01 : 2'b10;
            end else begin
                grant = req;
            end
        end
    end

endmodule

// File: rtl/uart_apb_arbiter.sv
// Arbitrates two local requesters onto a single APB3 master port.
module uart_apb_arbiter
    import uart_pkg::*;
#(
    parameter int unsigned APB_ADDR_WIDTH = 8,
    parameter int unsigned APB_DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT_CYCLES = UART_ARB_TIMEOUT_DFLT
) (
    input  logic                        i_apb_pclk,
    input  logic                        i_apb_presetn,
    input  logic [1:0]                  i_req,
    input  logic [2*APB_ADDR_WIDTH-1:0] i_addr,
    input  logic [2*APB_DATA_WIDTH-1:0] i_wdata,
    input  logic [1:0]                  i_write,
    output logic [1:0]                  o_done,
    output logic [APB_DATA_WIDTH-1:0]   o_rdata,
    output logic                        o_err,
    output logic                        o_timeout,
    output logic [APB_ADDR_WIDTH-1:0]   o_paddr,
    output logic [APB_DATA_WIDTH-1:0]   o_pwdata,
    output logic                        o_pwrite,
    output logic                        o_psel,
    output logic                        o_penable,
    input  logic [APB_DATA_WIDTH-1:0]   i_prdata,
    input  logic                        i_pready,
    input  logic                        i_pslverr
);

    localparam int unsigned AW = APB_ADDR_WIDTH;
    localparam int unsigned DW = APB_DATA_WIDTH;
    // Counter value seen during the last permitted ACCESS cycle.
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    uart_arb_state_t   state_q, state_d;
    logic              last_q;
    logic              win_q;
    logic [AW-1:0]     paddr_q;
    logic [DW-1:0]     pwdata_q;
    logic              pwrite_q;
    logic [DW-1:0]     rdata_q;
    logic              err_q;
    logic              tmo_q;
    logic [7:0]        wcnt_q;
    logic [1:0]        grant;
    logic              grant_idx;
    logic              tmo_hit;

    assign grant_idx = grant[1];
    assign tmo_hit   = !i_pready && (wcnt_q == TMO_LAST);

    uart_rr_arbiter u_rr (
        .req        (i_req),
        .last_grant (last_q),
        .update     (state_q == StIdle),
        .grant      (grant)
    );

    // State register.
    always_ff @(posedge i_apb_pclk or negedge i_apb_presetn) begin
        if (!i_apb_presetn) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: a fixed walk IDLE->SETUP->ACCESS->RESP, ACCESS ends on ready or timeout.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (|i_req) state_d = StSetup;
            StSetup:  state_d = StAccess;
            StAccess: if (i_pready || tmo_hit) state_d = StResp;
            StResp:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Transaction datapath: latch the winner in IDLE, capture the response in ACCESS.
    always_ff @(posedge i_apb_pclk or negedge i_apb_presetn) begin
        if (!i_apb_presetn) begin
            last_q   <= 1'b1;  // requester 0 owns priority out of reset
            win_q    <= 1'b0;
            paddr_q  <= '0;
            pwdata_q <= '0;
            pwrite_q <= 1'b0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            tmo_q    <= 1'b0;
            wcnt_q   <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (|i_req) begin
                        win_q    <= grant_idx;
                        last_q   <= grant_idx;
                        paddr_q  <= grant_idx ? i_addr[AW +: AW] : i_addr[0 +: AW];
                        pwdata_q <= grant_idx ? i_wdata[DW +: DW] : i_wdata[0 +: DW];
                        pwrite_q <= i_write[grant_idx];
                    end
                end
                StSetup: begin
                    wcnt_q <= '0;
                end
                StAccess: begin
                    if (i_pready) begin
                        rdata_q <= pwrite_q ? '0 : i_prdata;
                        err_q   <= i_pslverr;
                    end else if (tmo_hit) begin
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                        tmo_q   <= 1'b1;
                    end else begin
                        wcnt_q <= wcnt_q + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs decoded from the current phase; APB payload holds between transfers.
    always_comb begin
        o_psel    = (state_q == StSetup) || (state_q == StAccess);
        o_penable = (state_q == StAccess);
        o_done    = 2'b00;
        o_rdata   = '0;
        o_err     = 1'b0;
        if (state_q == StResp) begin
            o_done[win_q] = 1'b1;
            o_rdata       = rdata_q;
            o_err         = err_q;
        end
    end

    assign o_paddr   = paddr_q;
    assign o_pwdata  = pwdata_q;
    assign o_pwrite  = pwrite_q;
    assign o_timeout = tmo_q;

endmodule

// File: tb/tb_uart_apb_arbiter.sv
// Scoreboard bench for uart_apb_arbiter: stimulus queues expected responses,
// a completer model answers the APB port, a monitor checks every completion.
module tb_uart_apb_arbiter;

    localparam int AW  = 8;
    localparam int DW  = 32;
    localparam int TMO = 16;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [1:0]      i_req = '0;
    logic [2*AW-1:0] i_addr = '0;
    logic [2*DW-1:0] i_wdata = '0;
    logic [1:0]      i_write = '0;
    logic [1:0]      o_done;
    logic [DW-1:0]   o_rdata;
    logic            o_err, o_timeout;
    logic [AW-1:0]   o_paddr;
    logic [DW-1:0]   o_pwdata;
    logic            o_pwrite, o_psel, o_penable;
    logic [DW-1:0]   i_prdata = '0;
    logic            i_pready = 1'b0;
    logic            i_pslverr = 1'b0;

    uart_apb_arbiter #(
        .APB_ADDR_WIDTH (AW),
        .APB_DATA_WIDTH (DW),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .i_apb_pclk    (clk),
        .i_apb_presetn (rst_n),
        .i_req         (i_req),
        .i_addr        (i_addr),
        .i_wdata       (i_wdata),
        .i_write       (i_write),
        .o_done        (o_done),
        .o_rdata       (o_rdata),
        .o_err         (o_err),
        .o_timeout     (o_timeout),
        .o_paddr       (o_paddr),
        .o_pwdata      (o_pwdata),
        .o_pwrite      (o_pwrite),
        .o_psel        (o_psel),
        .o_penable     (o_penable),
        .i_prdata      (i_prdata),
        .i_pready      (i_pready),
        .i_pslverr     (i_pslverr)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          idx;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic        wr;
        logic [31:0] rdata;
        logic        err;
        logic        tmo;
        int          en_cycles;
    } exp_t;

    typedef struct {
        int          waits;
        logic [31:0] prdata;
        logic        slverr;
    } cpl_t;

    exp_t exp_q[$];
    cpl_t cpl_q[$];
    int   checks = 0;
    int   errors = 0;
    int   last_model = 1;     // requester granted most recently, per the rules
    logic tmo_model = 1'b0;   // sticky timeout the DUT ought to report
    int   en_cnt = 0;
    cpl_t cur;
    int   acnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Queue one transfer for requester r; callers add transfers in expected grant order.
    task automatic add_xfer(input int r, input logic [7:0] a, input logic [31:0] d,
                            input logic w, input int waits, input logic [31:0] prd,
                            input logic se);
        exp_t e;
        cpl_t c;
        i_addr[r*AW +: AW]  = a;
        i_wdata[r*DW +: DW] = d;
        i_write[r]          = w;
        c.waits  = waits;
        c.prdata = prd;
        c.slverr = se;
        cpl_q.push_back(c);
        e.idx       = r;
        e.addr      = a;
        e.wdata     = d;
        e.wr        = w;
        e.tmo       = (waits >= TMO);
        e.err       = e.tmo || se;
        e.rdata     = (e.tmo || w) ? 32'h0 : prd;
        e.en_cycles = e.tmo ? TMO : waits + 1;
        exp_q.push_back(e);
        last_model  = r;
    endtask

    // Raise the requests in mask and drop each one when its completion appears.
    task automatic run_round(input logic [1:0] mask);
        logic [1:0] pending;
        int n;
        pending = mask;
        i_req   = mask;
        n       = 0;
        while (pending != 2'b00 && n < 300) begin
            @(negedge clk);
            n++;
            for (int r = 0; r < 2; r++) begin
                if (o_done[r]) begin
                    pending[r] = 1'b0;
                    i_req[r]   = 1'b0;
                end
            end
        end
        check("round_complete", pending, 2'b00);
        if (pending != 2'b00) begin
            i_req = 2'b00;
            exp_q.delete();
            cpl_q.delete();
        end
    endtask

    task automatic random_xfer(input int r);
        int wsel[8];
        int waits;
        wsel = '{0, 1, 2, 3, 5, 15, 16, 20};
        waits = (($urandom_range(0, 3)) == 0) ? wsel[$urandom_range(5, 7)]
                                              : wsel[$urandom_range(0, 4)];
        add_xfer(r, 8'($urandom), $urandom, 1'($urandom), waits, $urandom,
                 ($urandom_range(0, 4) == 0));
    endtask

    // APB completer: checks the request phase, answers after the planned wait states.
    always @(negedge clk) begin
        if (!rst_n) begin
            i_pready  = 1'b0;
            i_pslverr = 1'b0;
            acnt      = 0;
        end else if (o_psel && !o_penable) begin
            if (cpl_q.size() > 0) cur = cpl_q.pop_front();
            else begin
                cur.waits = 0; cur.prdata = 32'h0; cur.slverr = 1'b0;
            end
            acnt     = 0;
            i_pready = 1'b0;
            if (exp_q.size() > 0) begin
                check("setup_paddr", o_paddr, exp_q[0].addr);
                check("setup_pwrite", o_pwrite, exp_q[0].wr);
                if (exp_q[0].wr) check("setup_pwdata", o_pwdata, exp_q[0].wdata);
            end
        end else if (o_psel && o_penable) begin
            acnt++;
            i_pready  = (acnt == cur.waits + 1);
            i_prdata  = i_pready ? cur.prdata : $urandom;
            i_pslverr = i_pready && cur.slverr;
        end else begin
            i_pready  = 1'b0;
            i_pslverr = 1'b0;
            i_prdata  = $urandom;
        end
    end

    // Monitor: every completion pops the scoreboard and is compared against it.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            en_cnt = 0;
        end else begin
            if (o_psel && o_penable) en_cnt++;
            if (o_done != 2'b00) begin
                check("done_onehot", $countones(o_done), 1);
                if (exp_q.size() == 0) begin
                    check("unexpected_done", o_done, 2'b00);
                end else begin
                    e = exp_q.pop_front();
                    if (e.tmo) tmo_model = 1'b1;
                    check("done_winner", o_done, 2'b01 << e.idx);
                    check("done_rdata", o_rdata, e.rdata);
                    check("done_err", o_err, e.err);
                    check("done_timeout", o_timeout, tmo_model);
                    check("access_cycles", en_cnt, e.en_cycles);
                end
                en_cnt = 0;
            end else begin
                check("quiet_outputs", {o_rdata, o_err}, '0);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not finish, got stall expected finish");
        $fatal(1);
    end

    initial begin
        logic [1:0] mask;
        logic [2:0] k_psel, k_pen;
        logic [1:0] k_done;
        int first;
        int n;

        // Reset state, both during and after reset.
        repeat (3) @(negedge clk);
        check("rst_apb_ctl", {o_psel, o_penable, o_pwrite}, 3'b000);
        check("rst_status", {o_done, o_err, o_timeout}, 4'b0000);
        check("rst_payload", {o_paddr, o_pwdata, o_rdata}, '0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_idle", {o_psel, o_penable, o_done}, 4'b0000);

        // Zero-wait write from requester 0: SETUP, ACCESS, done on consecutive cycles.
        add_xfer(0, 8'h04, 32'hA5, 1'b1, 0, 32'h0, 1'b0);
        i_req = 2'b01;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            k_psel[k] = o_psel;
            k_pen[k]  = o_penable;
            if (k == 2) k_done = o_done;
        end
        i_req = 2'b00;
        check("lat_psel", k_psel, 3'b011);
        check("lat_penable", k_pen, 3'b010);
        check("lat_done", k_done, 2'b01);
        check("apb_hold_addr", o_paddr, 8'h04);

        // Read with three wait states from requester 1.
        add_xfer(1, 8'h10, 32'h0, 1'b0, 3, 32'h1234, 1'b0);
        run_round(2'b10);

        // Contention: both held for two rounds; grants must alternate.
        for (int i = 0; i < 2; i++) begin
            first = 1 - last_model;
            add_xfer(first, 8'(8'h20 + i), $urandom, 1'b0, i, $urandom, 1'b0);
            add_xfer(1 - first, 8'(8'h30 + i), $urandom, 1'b1, 1, $urandom, 1'b0);
            run_round(2'b11);
        end

        // Completer error without timeout.
        add_xfer(0, 8'h44, 32'h0, 1'b0, 1, 32'hBEEF, 1'b1);
        run_round(2'b01);
        check("slverr_no_timeout", o_timeout, 1'b0);

        // Boundary: ready on the last permitted ACCESS cycle is not a timeout.
        add_xfer(1, 8'h50, 32'h0, 1'b0, TMO - 1, 32'h5A5A, 1'b0);
        run_round(2'b10);

        // Completer never ready: timeout, then the flag stays set.
        add_xfer(0, 8'h60, 32'h0, 1'b0, 100, 32'hFFFF, 1'b0);
        run_round(2'b01);
        check("psel_after_timeout", o_psel, 1'b0);
        add_xfer(1, 8'h61, 32'h77, 1'b1, 0, 32'h0, 1'b0);
        run_round(2'b10);
        check("timeout_sticky", o_timeout, 1'b1);

        // Randomized traffic.
        for (int i = 0; i < 40; i++) begin
            mask = 2'($urandom_range(1, 3));
            first = (mask == 2'b11) ? 1 - last_model : ((mask == 2'b01) ? 0 : 1);
            random_xfer(first);
            if (mask == 2'b11) random_xfer(1 - first);
            run_round(mask);
        end

        // Reset in the middle of ACCESS aborts without a completion.
        add_xfer(1, 8'h70, 32'hDEAD, 1'b1, 10, 32'h0, 1'b0);
        i_req = 2'b10;
        n = 0;
        while (!o_penable && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("reached_access", o_penable, 1'b1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_apb_ctl", {o_psel, o_penable}, 2'b00);
        check("abort_status", {o_done, o_err, o_timeout}, 4'b0000);
        check("abort_payload", {o_paddr, o_pwdata, o_rdata}, '0);
        i_req = 2'b00;
        exp_q.delete();
        cpl_q.delete();
        last_model = 1;
        tmo_model  = 1'b0;
        repeat (2) @(negedge clk);
        check("abort_no_done", o_done, 2'b00);
        rst_n = 1'b1;

        // After reset requester 0 regains priority under contention.
        add_xfer(0, 8'h80, 32'h11, 1'b1, 0, 32'h0, 1'b0);
        add_xfer(1, 8'h81, 32'h0, 1'b0, 2, 32'hCAFE, 1'b0);
        run_round(2'b11);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
